id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter DW, default 32, datapath width of all operand ports.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 id_valid  input  1  decode stage presents a bundle.
REQ-005 id_ready  output  1  stage accepts the bundle this cycle.
REQ-006 id_pc  input  DW  decoded instruction PC.
REQ-007 id_rs_data  input  DW  register-file operand A.
REQ-008 id_rt_data  input  DW  register-file operand B.
REQ-009 id_imm_ext  input  DW  sign-extended 16-bit immediate from decode.
REQ-010 id_imm_sel  input  1  1 selects id_imm_ext as operand B.
REQ-011 id_aluc  input  4  ALU operation code.
REQ-012 id_rd  input  5  destination register number.
REQ-013 flush  input  1  discard all held bundles (branch taken).
REQ-014 ex_valid  output  1  bundle available to execute.
REQ-015 ex_ready  input  1  execute consumes the bundle this cycle.
REQ-016 ex_pc, ex_opa, ex_opb  output  DW each  latched PC, operand A, selected operand B.
REQ-017 ex_aluc  output  4; ex_rd  output  5  latched control fields.
REQ-018 stall_cnt  output  16  count of cycles with ex_valid=1 and ex_ready=0.

Function
REQ-019 Transfer in SHALL occur on a clk edge where id_valid and id_ready are both 1; transfer out where ex_valid and ex_ready are both 1.
REQ-020 Operand B SHALL be selected at capture: ex_opb = id_imm_sel ? id_imm_ext : id_rt_data; no later re-selection.
REQ-021 Latency SHALL be one cycle: a bundle accepted at edge N appears on ex_* with ex_valid=1 after edge N.
REQ-022 ex_* data SHALL hold stable while ex_valid=1 and ex_ready=0.
REQ-023 Bundles SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-024 flush=1 at an edge SHALL clear all valid flags; any simultaneous input transfer is discarded; ex_valid=0 the next cycle.
REQ-025 ex_* data outputs SHALL be don't-care-free: registered, zero while never loaded.
REQ-026 stall_cnt SHALL increment per stalled cycle, saturate at 16'hFFFF, and not be cleared by flush.
REQ-027 Simultaneous in and out transfer with one entry held SHALL replace it with no bubble.

Reset
REQ-028 rst=1 SHALL immediately force ex_valid=0, all ex_* data to 0, stall_cnt=0, internal valid flags 0.
REQ-029 id_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 rst asserted mid-stall SHALL discard held bundles without producing a transfer.

Configuration
REQ-031 Macro ID_EX_SKID_EN defined: two-entry skid buffer; id_ready SHALL be a register output equal to "skid entry empty", giving full throughput with no combinational ex_ready->id_ready path; second entry drains before new input is shown.
REQ-032 ID_EX_SKID_EN undefined: single register; id_ready SHALL equal !ex_valid | ex_ready (combinational), still full throughput.
REQ-033 Transfer-level behaviour (order, latency, flush, stall_cnt) SHALL be identical in both builds.

Verification
REQ-034 Reset then id_valid=1, id_imm_sel=1, id_imm_ext=32'hFFFF8000, id_rt_data=5 -> next cycle ex_valid=1, ex_opb=32'hFFFF8000.
REQ-035 Stream 8 bundles, ex_ready=1 constant -> 8 outputs on 8 consecutive cycles, PCs in order, stall_cnt=0.
REQ-036 ex_ready=0 for 3 cycles with id_valid=1 -> ex_* stable, stall_cnt=3, SKID build accepts exactly one extra bundle then id_ready=0; no loss after ex_ready=1.
REQ-037 flush=1 while id_valid=1 and one bundle held -> ex_valid=0 next cycle, neither bundle ever appears.
REQ-038 Hold ex_ready=0 for 70000 cycles -> stall_cnt stops at 16'hFFFF.
REQ-039 Assert rst during a stall -> outputs zero immediately, id_ready=1 after release.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute handshake bundle for id_ex_stage.
// slave: the pipeline register; master: the surrounding decode/execute logic.
interface id_ex_stage_if #(
   parameter int DW = 32
);
   logic          id_valid;
   logic          id_ready;
   logic [DW-1:0] id_pc;
   logic [DW-1:0] id_rs_data;
   logic [DW-1:0] id_rt_data;
   logic [DW-1:0] id_imm_ext;
   logic          id_imm_sel;
   logic [3:0]    id_aluc;
   logic [4:0]    id_rd;
   logic          ex_valid;
   logic          ex_ready;
   logic [DW-1:0] ex_pc;
   logic [DW-1:0] ex_opa;
   logic [DW-1:0] ex_opb;
   logic [3:0]    ex_aluc;
   logic [4:0]    ex_rd;

   modport slave (
      input  id_valid, id_pc, id_rs_data, id_rt_data, id_imm_ext, id_imm_sel,
             id_aluc, id_rd, ex_ready,
      output id_ready, ex_valid, ex_pc, ex_opa, ex_opb, ex_aluc, ex_rd
   );

   modport master (
      output id_valid, id_pc, id_rs_data, id_rt_data, id_imm_ext, id_imm_sel,
             id_aluc, id_rd, ex_ready,
      input  id_ready, ex_valid, ex_pc, ex_opa, ex_opb, ex_aluc, ex_rd
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush and stall counter.
// Define ID_EX_SKID_EN for a two-entry skid buffer with a registered id_ready.
module id_ex_stage #(
   parameter int DW = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   id_ex_stage_if.slave bus,
   output logic [15:0]  stall_cnt
);
   typedef struct packed {
      logic [DW-1:0] pc;
      logic [DW-1:0] opa;
      logic [DW-1:0] opb;
      logic [3:0]    aluc;
      logic [4:0]    rd;
   } bundle_t;

   bundle_t     w_in;
   bundle_t     r_main;
   logic        r_main_vld;
   logic        w_take;
   logic        w_give;
   logic [15:0] r_stall_cnt;

   // Operand B is resolved here once; execute never sees id_imm_sel.
   always_comb begin
      w_in      = '0;
      w_in.pc   = bus.id_pc;
      w_in.opa  = bus.id_rs_data;
      w_in.opb  = bus.id_imm_sel ? bus.id_imm_ext : bus.id_rt_data;
      w_in.aluc = bus.id_aluc;
      w_in.rd   = bus.id_rd;
   end

   assign w_take = bus.id_valid & bus.id_ready;
   assign w_give = r_main_vld & bus.ex_ready;

`ifdef ID_EX_SKID_EN
   bundle_t r_skid;
   logic    r_skid_vld;

   // Skid entry has priority: it refills main before any new input is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main     <= '0;
         r_main_vld <= 1'b0;
         r_skid     <= '0;
         r_skid_vld <= 1'b0;
      end else if (flush) begin
         r_main_vld <= 1'b0;
         r_skid_vld <= 1'b0;
      end else if (r_skid_vld) begin
         if (w_give) begin
            r_main     <= r_skid;
            r_skid_vld <= 1'b0;
         end
      end else if (w_take) begin
         if (!r_main_vld || w_give) begin
            r_main     <= w_in;
            r_main_vld <= 1'b1;
         end else begin
            r_skid     <= w_in;
            r_skid_vld <= 1'b1;
         end
      end else if (w_give) begin
         r_main_vld <= 1'b0;
      end
   end

   assign bus.id_ready = ~r_skid_vld;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main     <= '0;
         r_main_vld <= 1'b0;
      end else if (flush) begin
         r_main_vld <= 1'b0;
      end else if (w_take) begin
         r_main     <= w_in;
         r_main_vld <= 1'b1;
      end else if (w_give) begin
         r_main_vld <= 1'b0;
      end
   end

   assign bus.id_ready = ~r_main_vld | bus.ex_ready;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (r_main_vld && !bus.ex_ready && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign bus.ex_valid = r_main_vld;
   assign bus.ex_pc    = r_main.pc;
   assign bus.ex_opa   = r_main.opa;
   assign bus.ex_opb   = r_main.opb;
   assign bus.ex_aluc  = r_main.aluc;
   assign bus.ex_rd    = r_main.rd;
   assign stall_cnt    = r_stall_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: scoreboard of accepted bundles checked at every
// output transfer, plus directed checks of reset, stall, flush and saturation.
module tb_id_ex_stage;
  localparam int DW = 32;
`ifdef ID_EX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [3:0]  aluc;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] stall_cnt;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned n_in = 0;
  int unsigned n_out = 0;
  int unsigned n_in0;
  exp_t        q[$];
  exp_t        got;
  exp_t        want;

  id_ex_stage_if #(.DW(DW)) bus ();

  id_ex_stage #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: decide at mid-cycle what the coming edge transfers.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (bus.ex_valid && bus.ex_ready) begin
        n_out++;
        chk("out_expected", (q.size() != 0), 1'b1);
        if (q.size() != 0) begin
          want = q.pop_front();
          got  = {bus.ex_pc, bus.ex_opa, bus.ex_opb, bus.ex_aluc, bus.ex_rd};
          chk("out_bundle", got, want);
        end
      end
      if (flush) begin
        q.delete();
      end else if (bus.id_valid && bus.id_ready) begin
        n_in++;
        q.push_back({bus.id_pc, bus.id_rs_data,
                     (bus.id_imm_sel ? bus.id_imm_ext : bus.id_rt_data),
                     bus.id_aluc, bus.id_rd});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] pc);
    bus.id_valid   = 1'b1;
    bus.id_pc      = pc;
    bus.id_rs_data = pc ^ 32'hA5A5_0000;
    bus.id_rt_data = pc + 32'd1;
    bus.id_imm_ext = {16'hFFFF, pc[15:0]} ^ 32'h0F0F_0000;
    bus.id_imm_sel = pc[2];
    bus.id_aluc    = pc[5:2];
    bus.id_rd      = pc[6:2];
  endtask

  initial begin
    int unsigned k;
    logic        acc;
    bus.id_valid   = 1'b0;
    bus.id_pc      = '0;
    bus.id_rs_data = '0;
    bus.id_rt_data = '0;
    bus.id_imm_ext = '0;
    bus.id_imm_sel = 1'b0;
    bus.id_aluc    = '0;
    bus.id_rd      = '0;
    bus.ex_ready   = 1'b1;

    // Reset state
    tick();
    tick();
    settle();
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_ex_pc", bus.ex_pc, 32'h0);
    chk("rst_ex_opb", bus.ex_opb, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 16'h0);
    tick();
    rst = 1'b0;
    settle();
    chk("post_rst_id_ready", bus.id_ready, 1'b1);

    // Immediate operand selected at capture
    tick();
    bus.id_valid   = 1'b1;
    bus.id_pc      = 32'h0000_0100;
    bus.id_rs_data = 32'h0000_0077;
    bus.id_rt_data = 32'h0000_0005;
    bus.id_imm_ext = 32'hFFFF_8000;
    bus.id_imm_sel = 1'b1;
    bus.id_aluc    = 4'h3;
    bus.id_rd      = 5'd9;
    tick();
    bus.id_valid = 1'b0;
    settle();
    chk("imm_ex_valid", bus.ex_valid, 1'b1);
    chk("imm_ex_opb", bus.ex_opb, 32'hFFFF_8000);

    // Back-to-back stream of 8 with ex_ready held high
    for (int unsigned i = 0; i <= 8; i++) begin
      tick();
      if (i < 8) offer(32'h200 + 4 * i);
      else bus.id_valid = 1'b0;
      settle();
      if (i > 0) begin
        chk("stream_ex_valid", bus.ex_valid, 1'b1);
        chk("stream_ex_pc", bus.ex_pc, 32'h200 + 4 * (i - 1));
      end
    end
    chk("stream_stall_cnt", stall_cnt, 16'h0);

    // Three stalled cycles with input still offered
    tick();
    k = 0;
    offer(32'h300);
    bus.ex_ready = 1'b0;
    n_in0 = n_in;
    settle();
    acc = bus.id_valid && bus.id_ready;
    for (int unsigned c = 0; c < 4; c++) begin
      tick();
      if (acc) k++;
      offer(32'h300 + 4 * k);
      if (c == 3) begin
        bus.ex_ready = 1'b1;
        bus.id_valid = 1'b0;
      end
      settle();
      acc = bus.id_valid && bus.id_ready;
      if (c < 3) begin
        chk("stall_ex_valid", bus.ex_valid, 1'b1);
        chk("stall_ex_pc", bus.ex_pc, 32'h300);
        chk("stall_id_ready", bus.id_ready, (c == 0) ? SKID : 1'b0);
      end
    end
    chk("stall_cnt_3", stall_cnt, 16'd3);
    for (int unsigned c = 0; c < 4; c++) tick();
    settle();
    chk("stall_accepted", n_in - n_in0, SKID ? 32'd2 : 32'd1);
    chk("stall_drained", q.size(), 0);
    chk("stall_drain_valid", bus.ex_valid, 1'b0);

    // Flush with one bundle held and another offered
    tick();
    offer(32'h400);
    bus.ex_ready = 1'b0;
    settle();
    tick();
    offer(32'h404);
    flush = 1'b1;
    settle();
    tick();
    flush        = 1'b0;
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b1;
    settle();
    chk("flush_ex_valid", bus.ex_valid, 1'b0);
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      settle();
      chk("flush_stays_empty", bus.ex_valid, 1'b0);
    end
    chk("flush_keeps_stall_cnt", stall_cnt, 16'd4);

    // Long stall: counter saturates
    tick();
    offer(32'h600);
    bus.ex_ready = 1'b0;
    settle();
    tick();
    bus.id_valid = 1'b0;
    settle();
    chk("sat_start", stall_cnt, 16'd4);
    repeat (65530) tick();
    settle();
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    tick();
    settle();
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    repeat (4500) tick();
    settle();
    chk("sat_hold", stall_cnt, 16'hFFFF);
    chk("sat_ex_pc", bus.ex_pc, 32'h600);

    // Reset in the middle of the stall
    tick();
    rst          = 1'b1;
    bus.ex_ready = 1'b1;
    #1;
    chk("arst_ex_valid", bus.ex_valid, 1'b0);
    chk("arst_ex_pc", bus.ex_pc, 32'h0);
    chk("arst_ex_opa", bus.ex_opa, 32'h0);
    chk("arst_stall_cnt", stall_cnt, 16'h0);
    tick();
    rst          = 1'b0;
    bus.ex_ready = 1'b0;
    settle();
    chk("arst_id_ready", bus.id_ready, 1'b1);
    chk("arst_no_output", bus.ex_valid, 1'b0);

    // Register operand selected; later imm_sel change must not leak through
    tick();
    offer(32'h500);
    bus.id_imm_sel = 1'b0;
    bus.id_rt_data = 32'h0000_1234;
    bus.id_imm_ext = 32'hDEAD_0000;
    settle();
    tick();
    bus.id_valid   = 1'b0;
    bus.id_imm_sel = 1'b1;
    settle();
    chk("rt_ex_valid", bus.ex_valid, 1'b1);
    chk("rt_ex_opb", bus.ex_opb, 32'h0000_1234);
    tick();
    bus.ex_ready = 1'b1;
    settle();
    chk("rt_opb_stable", bus.ex_opb, 32'h0000_1234);
    tick();
    settle();
    chk("rt_done_valid", bus.ex_valid, 1'b0);
    chk("rt_stall_cnt", stall_cnt, 16'd1);

    chk("final_queue_empty", q.size(), 0);
    chk("final_out_count", n_out, SKID ? 32'd12 : 32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
